i2lbs_database_arbiter: RTL and testbench
=========================================

I2LBS_DATABASE_ARBITER -- requirements
Module: i2lbs_database_arbiter

Interface
REQ-001 Parameter NUM_REQUESTER, default 4: number of I2LBS instances sharing one classifier database stream; legal range 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 4095: maximum STREAM cycles per grant before forced release; legal range 1..65535.
REQ-003 Parameter GRANT_INDEX_WIDTH, default 2: width of o_grant_index; equals clog2(NUM_REQUESTER).
REQ-004 Port clk_fpga, input, 1: single clock; all logic is rising-edge.
REQ-005 Port reset_fpga, input, 1: synchronous, active-high reset.
REQ-006 Port i_request, input, NUM_REQUESTER: per-instance level database request; bit n is o_database_request of instance n.
REQ-007 Port i_db_end, input, 1: one-cycle pulse from database reader marking the end of the full classifier pass.
REQ-008 Port o_grant, output, NUM_REQUESTER: one-hot or zero; the granted bit routes the database stream to that instance.
REQ-009 Port o_grant_index, output, GRANT_INDEX_WIDTH: binary index of the current or most recent grant.
REQ-010 Port o_db_start, output, 1: one-cycle pulse that restarts the database reader at index 0.
REQ-011 Port o_db_busy, output, 1: high in states START and STREAM.
REQ-012 Port o_abort, output, 1: one-cycle pulse when a grant ends without i_db_end.
REQ-013 Port o_timeout, output, 1: one-cycle pulse when a grant ends by timeout.

Function
REQ-014 The FSM SHALL have states IDLE, START, STREAM and RELEASE; all outputs are registered or decoded from registered state only.
REQ-015 In IDLE with any i_request bit set, the block SHALL select the requester by round-robin, starting at (last_grant+1) mod NUM_REQUESTER, and enter START on the next edge.
REQ-016 In IDLE with i_request all zero, the block SHALL remain in IDLE.
REQ-017 o_grant and o_grant_index SHALL be valid from the first START cycle through the last STREAM cycle; o_grant SHALL be zero in IDLE and RELEASE.
REQ-018 START SHALL last exactly one cycle with o_db_start=1, then go to STREAM; latency from request sampled in IDLE to o_db_start is 1 cycle.
REQ-019 In STREAM, the block SHALL count cycles in a 16-bit counter that is cleared on entering STREAM.
REQ-020 In STREAM, i_db_end=1 SHALL cause a transition to RELEASE (normal completion).
REQ-021 In STREAM, if the granted i_request bit drops and i_db_end=0, the block SHALL pulse o_abort and go to RELEASE.
REQ-022 In STREAM, if the counter reaches TIMEOUT_CYCLES-1 with i_db_end=0, the block SHALL pulse o_timeout and o_abort and go to RELEASE.
REQ-023 Simultaneous events SHALL be resolved by priority: i_db_end over request drop over timeout; only one outcome is reported.
REQ-024 i_db_end outside STREAM SHALL be ignored.
REQ-025 RELEASE SHALL last one cycle, update last_grant to the released index, and return to IDLE; a new grant therefore needs at least 2 cycles after completion.
REQ-026 Request changes during START SHALL NOT alter the grant; a drop is acted on in the first STREAM cycle.

Reset
REQ-027 Reset SHALL force state IDLE, o_grant=0, o_grant_index=0, o_db_start=0, o_db_busy=0, o_abort=0, o_timeout=0, counter=0, and last_grant=NUM_REQUESTER-1, so that requester 0 wins first.
REQ-028 Reset asserted mid-grant SHALL take effect on the next edge with no o_abort pulse.

Structure
REQ-029 The state encoding localparams and the database handshake widths SHALL reside in the shared i2lbs package.
REQ-030 Round-robin selection SHALL be a combinational sub-module, i2lbs_rr_picker (inputs: request vector, last index; outputs: one-hot, index, any).

Verification
REQ-031 Reset, then i_request=4'b0101 -> grant 4'b0001, o_db_start 1 cycle later; after i_db_end, grant 4'b0100.
REQ-032 All four requests held continuously -> grant order 0,1,2,3,0, with exactly one o_db_start per grant.
REQ-033 Granted request drops in the 5th STREAM cycle -> o_abort pulse, o_timeout=0, RELEASE then IDLE.
REQ-034 TIMEOUT_CYCLES=8, no i_db_end -> o_timeout and o_abort on the 8th STREAM cycle, grant cleared on the next cycle.
REQ-035 i_db_end and request drop in the same cycle -> normal completion, o_abort=0.
REQ-036 reset_fpga pulsed mid-STREAM -> all outputs zero on the next cycle, and the next grant goes to requester 0.

Source files
------------

// File: rtl/i2lbs_pkg.sv
// Shared definitions for the I2LBS database arbiter: FSM state encoding,
// database handshake widths and a small timeout helper.
package i2lbs_pkg;

  // State encodings, kept as named constants so other blocks can decode them.
  localparam int         STATE_W        = 2;
  localparam logic [1:0] ST_ENC_IDLE    = 2'd0;
  localparam logic [1:0] ST_ENC_START   = 2'd1;
  localparam logic [1:0] ST_ENC_STREAM  = 2'd2;
  localparam logic [1:0] ST_ENC_RELEASE = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = ST_ENC_IDLE,
    ST_START   = ST_ENC_START,
    ST_STREAM  = ST_ENC_STREAM,
    ST_RELEASE = ST_ENC_RELEASE
  } db_state_e;

  // Database reader handshake: single-bit strobes, 16-bit stream cycle counter.
  localparam int DB_STROBE_W = 1;
  localparam int DB_CNT_W    = 16;

  // True on the last allowed STREAM cycle of a grant.
  function automatic logic count_expired(input logic [DB_CNT_W-1:0] cnt,
                                         input int unsigned         limit);
    return cnt == DB_CNT_W'(limit - 1);
  endfunction

endpackage

// File: rtl/i2lbs_rr_picker.sv
// Combinational round-robin picker: searches the request vector starting
// one position after the last granted index, wrapping modulo N.
module i2lbs_rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_request,
  input  logic [IDX_W-1:0] i_last,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_index,
  output logic             o_any
);

  logic [IDX_W-1:0] cand_idx [N];
  logic [N-1:0]     cand_hit;

  // Candidate gi is the requester at (last + 1 + gi) mod N; the sum needs one
  // extra bit so a single conditional subtract implements the wrap.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum          = {1'b0, i_last} + (IDX_W+1)'(gi + 1);
    assign cand_idx[gi] = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                 : IDX_W'(sum);
    assign cand_hit[gi] = i_request[cand_idx[gi]];
  end

  // Priority over candidates: scan from the far end so the nearest hit wins.
  always_comb begin
    o_index = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        o_index = cand_idx[k];
      end
    end
    o_any    = |i_request;
    o_onehot = o_any ? (N'(1) << o_index) : '0;
  end

endmodule

// File: rtl/i2lbs_database_arbiter.sv
// Arbiter granting one shared classifier database stream to one of several
// I2LBS instances at a time, with round-robin fairness, abort on request
// drop and a per-grant timeout.
module i2lbs_database_arbiter
  import i2lbs_pkg::*;
#(
  parameter int NUM_REQUESTER     = 4,
  parameter int TIMEOUT_CYCLES    = 4095,
  parameter int GRANT_INDEX_WIDTH = 2
) (
  input  logic                         clk_fpga,
  input  logic                         reset_fpga,
  input  logic [NUM_REQUESTER-1:0]     i_request,
  input  logic [DB_STROBE_W-1:0]       i_db_end,
  output logic [NUM_REQUESTER-1:0]     o_grant,
  output logic [GRANT_INDEX_WIDTH-1:0] o_grant_index,
  output logic [DB_STROBE_W-1:0]       o_db_start,
  output logic                         o_db_busy,
  output logic                         o_abort,
  output logic                         o_timeout
);

  db_state_e                    state_q, state_d;
  logic [NUM_REQUESTER-1:0]     grant_q, grant_d;
  logic [GRANT_INDEX_WIDTH-1:0] index_q, index_d;
  logic [GRANT_INDEX_WIDTH-1:0] last_q, last_d;
  logic [DB_CNT_W-1:0]          count_q, count_d;
  logic                         abort_q, abort_d;
  logic                         timeout_q, timeout_d;

  logic [NUM_REQUESTER-1:0]     pick_onehot;
  logic [GRANT_INDEX_WIDTH-1:0] pick_index;
  logic                         pick_any;

  i2lbs_rr_picker #(
    .N     (NUM_REQUESTER),
    .IDX_W (GRANT_INDEX_WIDTH)
  ) u_picker (
    .i_request (i_request),
    .i_last    (last_q),
    .o_onehot  (pick_onehot),
    .o_index   (pick_index),
    .o_any     (pick_any)
  );

  // Next-state and next-output logic; abort/timeout default to zero so they
  // only pulse on the edge that ends a grant.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    index_d   = index_q;
    last_d    = last_q;
    count_d   = count_q;
    abort_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (pick_any) begin
          grant_d = pick_onehot;
          index_d = pick_index;
          state_d = ST_START;
        end
      end
      ST_START: begin
        // Grant is frozen here; request changes are only looked at in STREAM.
        count_d = '0;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        count_d = count_q + DB_CNT_W'(1);
        if (i_db_end[0]) begin
          state_d = ST_RELEASE;
          grant_d = '0;
        end else if ((i_request & grant_q) == '0) begin
          abort_d = 1'b1;
          state_d = ST_RELEASE;
          grant_d = '0;
        end else if (count_expired(count_q, TIMEOUT_CYCLES)) begin
          abort_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_RELEASE;
          grant_d   = '0;
        end
      end
      ST_RELEASE: begin
        last_d  = index_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and output registers; reset points last_grant at the top requester
  // so requester 0 is first in line.
  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      index_q   <= '0;
      last_q    <= GRANT_INDEX_WIDTH'(NUM_REQUESTER - 1);
      count_q   <= '0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      index_q   <= index_d;
      last_q    <= last_d;
      count_q   <= count_d;
      abort_q   <= abort_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_grant       = grant_q;
  assign o_grant_index = index_q;
  assign o_db_start    = DB_STROBE_W'(state_q == ST_START);
  assign o_db_busy     = (state_q == ST_START) || (state_q == ST_STREAM);
  assign o_abort       = abort_q;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_i2lbs_database_arbiter.sv
// Directed bench for i2lbs_database_arbiter (4 requesters, 8-cycle timeout).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// Abort/timeout pulses are registered, so they show in the RELEASE cycle.
module tb_i2lbs_database_arbiter;

  logic       clk_fpga = 1'b0;
  logic       reset_fpga;
  logic [3:0] i_request;
  logic       i_db_end;
  logic [3:0] o_grant;
  logic [1:0] o_grant_index;
  logic       o_db_start;
  logic       o_db_busy;
  logic       o_abort;
  logic       o_timeout;

  int n_checks = 0;
  int n_bad    = 0;

  i2lbs_database_arbiter #(
    .NUM_REQUESTER     (4),
    .TIMEOUT_CYCLES    (8),
    .GRANT_INDEX_WIDTH (2)
  ) dut (
    .clk_fpga      (clk_fpga),
    .reset_fpga    (reset_fpga),
    .i_request     (i_request),
    .i_db_end      (i_db_end),
    .o_grant       (o_grant),
    .o_grant_index (o_grant_index),
    .o_db_start    (o_db_start),
    .o_db_busy     (o_db_busy),
    .o_abort       (o_abort),
    .o_timeout     (o_timeout)
  );

  always #5 clk_fpga = ~clk_fpga;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_fpga);
    #1;
  endtask

  // From IDLE with requests present: expect a grant, stream n_stream cycles,
  // finish with i_db_end, and return in IDLE.
  task automatic run_grant(input string tag, input logic [3:0] exp_grant,
                           input logic [1:0] exp_idx, input int n_stream);
    step();
    check({tag, " start.grant"}, 32'(o_grant), 32'(exp_grant));
    check({tag, " start.idx"}, 32'(o_grant_index), 32'(exp_idx));
    check({tag, " start.pulse"}, 32'(o_db_start), 32'd1);
    for (int s = 1; s <= n_stream; s++) begin
      step();
      check({tag, " stream.pulse"}, 32'(o_db_start), 32'd0);
      check({tag, " stream.busy"}, 32'(o_db_busy), 32'd1);
      check({tag, " stream.grant"}, 32'(o_grant), 32'(exp_grant));
      if (s == n_stream) i_db_end = 1'b1;
    end
    step();
    i_db_end = 1'b0;
    check({tag, " rel.grant"}, 32'(o_grant), 32'd0);
    check({tag, " rel.abort"}, 32'(o_abort), 32'd0);
    check({tag, " rel.busy"}, 32'(o_db_busy), 32'd0);
    check({tag, " rel.pulse"}, 32'(o_db_start), 32'd0);
    step();
    check({tag, " idle.grant"}, 32'(o_grant), 32'd0);
    check({tag, " idle.idx"}, 32'(o_grant_index), 32'(exp_idx));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_fpga = 1'b1;
    i_request  = 4'b0000;
    i_db_end   = 1'b0;
    step();
    step();
    check("rst grant", 32'(o_grant), 32'd0);
    check("rst idx", 32'(o_grant_index), 32'd0);
    check("rst start", 32'(o_db_start), 32'd0);
    check("rst busy", 32'(o_db_busy), 32'd0);
    check("rst abort", 32'(o_abort), 32'd0);
    check("rst timeout", 32'(o_timeout), 32'd0);
    reset_fpga = 1'b0;

    // Idle with no requests stays idle; a stray db_end is ignored.
    i_db_end = 1'b1;
    step();
    i_db_end = 1'b0;
    step();
    check("idle busy", 32'(o_db_busy), 32'd0);
    check("idle abort", 32'(o_abort), 32'd0);
    check("idle grant", 32'(o_grant), 32'd0);

    // 0101: requester 0 first, then requester 2.
    i_request = 4'b0101;
    run_grant("rr0101a", 4'b0001, 2'd0, 2);
    run_grant("rr0101b", 4'b0100, 2'd2, 1);
    i_request = 4'b0000;
    step();
    check("noreq grant", 32'(o_grant), 32'd0);
    check("noreq busy", 32'(o_db_busy), 32'd0);

    // All four held: order 0,1,2,3,0 after a fresh reset.
    reset_fpga = 1'b1;
    step();
    reset_fpga = 1'b0;
    i_request  = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      run_grant($sformatf("all%0d", g), 4'(1 << (g % 4)), 2'(g % 4), 2);
    end

    // Request drop in the 5th STREAM cycle (last grant was 0).
    i_request = 4'b0010;
    step();
    check("drop start.grant", 32'(o_grant), 32'h2);
    for (int s = 1; s <= 5; s++) begin
      step();
      check("drop stream.abort", 32'(o_abort), 32'd0);
    end
    i_request = 4'b0000;
    step();
    check("drop rel.abort", 32'(o_abort), 32'd1);
    check("drop rel.timeout", 32'(o_timeout), 32'd0);
    check("drop rel.grant", 32'(o_grant), 32'd0);
    check("drop rel.busy", 32'(o_db_busy), 32'd0);
    step();
    check("drop idle.abort", 32'(o_abort), 32'd0);
    check("drop idle.busy", 32'(o_db_busy), 32'd0);

    // Timeout: 8 STREAM cycles without db_end (last grant was 1).
    i_request = 4'b0100;
    step();
    check("to start.grant", 32'(o_grant), 32'h4);
    for (int s = 1; s <= 8; s++) begin
      step();
      check("to stream.busy", 32'(o_db_busy), 32'd1);
      check("to stream.timeout", 32'(o_timeout), 32'd0);
      check("to stream.grant", 32'(o_grant), 32'h4);
    end
    step();
    check("to rel.timeout", 32'(o_timeout), 32'd1);
    check("to rel.abort", 32'(o_abort), 32'd1);
    check("to rel.grant", 32'(o_grant), 32'd0);
    i_request = 4'b0000;
    step();
    check("to idle.timeout", 32'(o_timeout), 32'd0);
    check("to idle.abort", 32'(o_abort), 32'd0);

    // db_end and drop together: normal completion (last grant was 2).
    i_request = 4'b1000;
    step();
    check("both start.idx", 32'(o_grant_index), 32'd3);
    step();
    step();
    i_request = 4'b0000;
    i_db_end  = 1'b1;
    step();
    i_db_end = 1'b0;
    check("both rel.abort", 32'(o_abort), 32'd0);
    check("both rel.timeout", 32'(o_timeout), 32'd0);
    check("both rel.grant", 32'(o_grant), 32'd0);
    step();

    // Drop during START keeps the grant; abort comes after first STREAM cycle.
    i_request = 4'b0001;
    step();
    check("sdrop start.grant", 32'(o_grant), 32'h1);
    i_request = 4'b0000;
    step();
    check("sdrop stream.grant", 32'(o_grant), 32'h1);
    check("sdrop stream.busy", 32'(o_db_busy), 32'd1);
    step();
    check("sdrop rel.abort", 32'(o_abort), 32'd1);
    step();

    // Reset mid-STREAM (last grant was 0, so requester 2 wins first).
    i_request = 4'b0100;
    step();
    check("mrst start.idx", 32'(o_grant_index), 32'd2);
    step();
    step();
    reset_fpga = 1'b1;
    step();
    check("mrst grant", 32'(o_grant), 32'd0);
    check("mrst idx", 32'(o_grant_index), 32'd0);
    check("mrst busy", 32'(o_db_busy), 32'd0);
    check("mrst start", 32'(o_db_start), 32'd0);
    check("mrst abort", 32'(o_abort), 32'd0);
    check("mrst timeout", 32'(o_timeout), 32'd0);
    reset_fpga = 1'b0;
    i_request  = 4'b1111;
    step();
    check("mrst next.grant", 32'(o_grant), 32'h1);
    check("mrst next.pulse", 32'(o_db_start), 32'd1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
